// File: rtl/signp_scheduler.sv
// Shares one signP pipeline between requesters A and B: job-granular round-robin
// arbitration, serialised term pairs, and a tag pipeline returning each job's sign.
module signp_scheduler #(
    parameter int W         = 11,
    parameter int LAT       = 3,
    parameter int MAX_TERMS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] a_i1,
    input  logic [W-1:0] a_i2,
    input  logic         a_last,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [W-1:0] b_i1,
    input  logic [W-1:0] b_i2,
    input  logic         b_last,
    output logic [W-1:0] p_i1,
    output logic [W-1:0] p_i2,
    output logic         p_re,
    input  logic         p_s,
    output logic         res_valid,
    output logic         res_id,
    output logic         res_sign,
    output logic         res_err,
    output logic         busy
);
    localparam int CW = $clog2(MAX_TERMS + 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  p_i1_q, p_i2_q;
    logic          p_re_q, p_id_q, p_err_q;
    logic [LAT-1:0] tag_vld_q, tag_id_q, tag_err_q;
    logic          res_valid_q, res_id_q, res_sign_q, res_err_q;

    logic          sel_b, x_valid, x_last, xfer, at_max, fin, forced;
    logic [W-1:0]  x_i1, x_i2;
    logic [CW-1:0] cnt_inc;

    assign sel_b   = (state_q == GRANT_B);
    assign x_valid = sel_b ? b_valid : a_valid;
    assign x_last  = sel_b ? b_last  : a_last;
    assign x_i1    = sel_b ? b_i1    : a_i1;
    assign x_i2    = sel_b ? b_i2    : a_i2;
    assign xfer    = (state_q != IDLE) & x_valid;
    assign cnt_inc = cnt_q + 1'b1;
    assign at_max  = (cnt_inc == CW'(MAX_TERMS));
    assign fin     = xfer & (x_last | at_max);
    // Error only when the term limit, not the requester, ended the job.
    assign forced  = fin & ~x_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || !ptr_q)) state_d = GRANT_A;
                else if (b_valid)                    state_d = GRANT_B;
            end
            GRANT_A, GRANT_B: if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_ready = (state_q == GRANT_A);
        b_ready = (state_q == GRANT_B);
    end

    // Pointer moves only on job completion, so a tie goes to whoever did not just finish.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = fin ? '0 : cnt_inc;
            if (fin) ptr_d = ~sel_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            p_i1_q      <= '0;
            p_i2_q      <= '0;
            p_re_q      <= 1'b0;
            p_id_q      <= 1'b0;
            p_err_q     <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            tag_err_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_sign_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            p_i1_q      <= xfer ? x_i1 : '0;
            p_i2_q      <= xfer ? x_i2 : '0;
            p_re_q      <= fin;
            p_id_q      <= sel_b;
            p_err_q     <= forced;
            tag_vld_q   <= LAT'({tag_vld_q, p_re_q});
            tag_id_q    <= LAT'({tag_id_q, p_id_q});
            tag_err_q   <= LAT'({tag_err_q, p_err_q});
            res_valid_q <= tag_vld_q[LAT-1];
            if (tag_vld_q[LAT-1]) begin
                res_id_q   <= tag_id_q[LAT-1];
                res_sign_q <= p_s;
                res_err_q  <= tag_err_q[LAT-1];
            end
        end
    end

    assign p_i1      = p_i1_q;
    assign p_i2      = p_i2_q;
    assign p_re      = p_re_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sign  = res_sign_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != IDLE) | (|tag_vld_q) | res_valid_q;
endmodule

// File: doc/signp_scheduler.md
Name: signp_scheduler

Overview:
- Shares one signP pipeline between two requesters, A and B.
- Each requester submits a job: a stream of (i1, i2) term pairs, with the last pair flagged.
- The block arbitrates at job granularity and serialises the pairs into signP, pulsing re on each job's final pair.
- It tags each job in flight and returns signP's sign output s to the owning requester.
- It sits between the requester front-ends and the signP instance.

Parameters:
- W, 11: width of the i1/i2 operands.
- LAT, 3: signP latency. s is valid exactly LAT cycles after the cycle in which signP's re input is high.
- MAX_TERMS, 8: maximum number of pairs per job. The job is force-terminated at this count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a_valid  in  1  requester A has a pair available.
- a_ready  out  1  scheduler accepts A's pair this cycle.
- a_i1  in  W  A operand 1.
- a_i2  in  W  A operand 2.
- a_last  in  1  the current A pair is the last of its job.
- b_valid, b_ready, b_i1, b_i2, b_last: same as the A ports, for requester B.
- p_i1  out  W  signP operand 1.
- p_i2  out  W  signP operand 2.
- p_re  out  1  signP re: marks the final pair of a job.
- p_s  in  1  signP sign output.
- res_valid  out  1  single-cycle result pulse.
- res_id  out  1  result owner: 0 = A, 1 = B.
- res_sign  out  1  sign returned by signP for that job.
- res_err  out  1  job was force-terminated at MAX_TERMS.
- busy  out  1  a job is granted, or any result is still in flight.

Behaviour:

Reset values:
- All outputs are 0.
- State is IDLE.
- Round-robin pointer = A.
- Term counter = 0.
- Tag pipeline cleared.

State machine (IDLE, GRANT_A, GRANT_B):
- In IDLE:
  - If only one valid is high, grant that requester.
  - If both valids are high, grant the requester named by the pointer.
  - The grant is registered: the state becomes GRANT_x on the next edge.
  - No transfer happens in IDLE; a_ready and b_ready are both 0.
- In GRANT_x:
  - x_ready = 1; the other requester's ready = 0.
  - A transfer occurs on any cycle with x_valid & x_ready.
  - Each transfer increments the term counter.
  - The final transfer is the one with x_last = 1, or the one where the counter reaches MAX_TERMS.
  - On the final transfer: next state = IDLE, pointer = the other requester, counter = 0.
  - Cycles in GRANT_x with x_valid = 0 are stall cycles: no transfer, state held.

Datapath drive (registered, one cycle after the handshake):
- After a transfer cycle: p_i1/p_i2 = the transferred operands, p_re = 1 only for the final transfer.
- In every non-transfer cycle (idle, stall, bubble): p_i1 = p_i2 = 0 and p_re = 0. A zero pair is signP's neutral term.
- There is exactly one zero bubble cycle between consecutive jobs, caused by the IDLE grant cycle.

Result return:
- A tag shift register, LAT stages deep, carries {valid, id, err}. Stage 0 is loaded in the cycle p_re = 1.
- When the last stage is valid, the next edge registers res_valid = 1, res_id, res_err, and res_sign = p_s.
- Latency: res_valid rises LAT+2 cycles after the final handshake cycle (5 cycles for LAT = 3).
- There is no result backpressure; results come back in job order.

Err rule:
- res_err = 1 only when the MAX_TERMS count triggered termination while x_last was 0.
- If x_last = 1 on the MAX_TERMS-th pair, res_err = 0.
- After a forced termination, subsequent pairs from that requester start a new job.

Boundary rules:
- A single-pair job (last on the first pair) is legal; p_re is high on that pair.
- The jobs of each requester alternate under constant contention.
- The pointer advances only on job completion, not on grant.

Reset mid-job:
- Asynchronous clear of everything, including in-flight tags.
- In-flight results are discarded; no res_valid is emitted for them.
- Requesters must resubmit.

busy = (state != IDLE) | (any tag stage valid) | res_valid.

Test Plan:
1. Job A = (10,10), (200,100), (300,300), (178,168) with last on the 4th pair; signP model returns 1. Required: p_re high on the 178/168 cycle only, p_i1/p_i2 zero before and after, and 5 cycles after the last handshake res_valid = 1, res_id = 0, res_sign = 1, res_err = 0.
2. Job B = (10,10), (200,100), (300,300), (795,22) -> res_id = 1, res_sign = 0. Then A and B are both valid from reset with continuous jobs. Required grant order A, B, A, B; one zero bubble between jobs; results in the same order.
3. A holds a_last = 0 for 10 pairs of (5,3). Required: p_re on the 8th pair, res_err = 1; pairs 9 and 10 form a new job. A separate job with last on the 8th pair gives res_err = 0.
4. A drops a_valid for 3 cycles mid-job. Required: state held, a_ready stays 1, zeros driven to signP during the gap, no p_re, and the result is equal to the no-stall run.
5. A single-pair job (7,2, last) -> p_re on its only pair, result after 5 cycles. Immediately afterwards B is granted after one bubble.
6. Reset asserted asynchronously, mid-clock, during A's 3rd pair with one earlier result still in flight. Required: all outputs go to 0 immediately, no res_valid afterwards, pointer = A, and the next job proceeds normally after deassertion.
